// File: rtl/cosim_reg_write_deser_if.sv
// cosim_reg_write_deser_if: DPI word stream in, rebuilt register-write records out.
interface cosim_reg_write_deser_if #(
    parameter int DPI_W  = 32,
    parameter int FREG_W = 128
);
    logic              word_valid_i;
    logic              word_ready_o;
    logic [DPI_W-1:0]  word_data_i;
    logic              word_first_i;
    logic              rec_valid_o;
    logic              rec_ready_i;
    logic [3:0]        rec_type_o;
    logic [59:0]       rec_id_o;
    logic [FREG_W-1:0] rec_value_o;
    logic [31:0]       rec_cnt_o;
    logic              err_o;
    modport master (
        output word_valid_i, word_data_i, word_first_i, rec_ready_i,
        input  word_ready_o, rec_valid_o, rec_type_o, rec_id_o, rec_value_o, rec_cnt_o, err_o
    );
    modport slave (
        input  word_valid_i, word_data_i, word_first_i, rec_ready_i,
        output word_ready_o, rec_valid_o, rec_type_o, rec_id_o, rec_value_o, rec_cnt_o, err_o
    );
endinterface

// File: rtl/cosim_reg_write_deser.sv
// cosim_reg_write_deser: rebuilds {type, id, value} register-write records from DPI words into a small FIFO.
// Optional word_first_i protocol check is enabled by defining COSIM_DESER_PROTO_CHECK_EN.
module cosim_reg_write_deser #(
    parameter int XREG_W    = 64,
    parameter int FREG_W    = 128,
    parameter int DPI_W     = 32,
    parameter int OUT_DEPTH = 2
) (
    input logic clk_i,
    input logic rst_i,
    cosim_reg_write_deser_if.slave bus
);
    localparam int WORDS = XREG_W / DPI_W + FREG_W / DPI_W;
    localparam int REC_W = WORDS * DPI_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam int PTR_W = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);

    logic [IDX_W-1:0] idx, idx_next, widx;
    logic [REC_W-1:0] asm_q, asm_next, head;
    logic [REC_W-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      rec_cnt;
    logic             err, err_set, hs, store, push, pop, full;

    assign full = count == CNT_W'(OUT_DEPTH);
    assign hs   = bus.word_valid_i && !full;
    assign pop  = count != '0 && bus.rec_ready_i;
    assign push = store && widx == LAST;

`ifdef COSIM_DESER_PROTO_CHECK_EN
    logic restart, stray;
    assign restart = hs && bus.word_first_i && idx != '0;
    assign stray   = hs && !bus.word_first_i && idx == '0;
    assign err_set = restart || stray;
    assign store   = hs && !stray;
    // a misplaced first word restarts assembly with itself as word 0
    assign widx    = restart ? '0 : idx;
`else
    logic unused_first;
    assign unused_first = bus.word_first_i;
    assign err_set      = 1'b0;
    assign store        = hs;
    assign widx         = idx;
`endif

    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < WORDS; k++)
            if (widx == IDX_W'(k)) asm_next[k*DPI_W +: DPI_W] = bus.word_data_i;
        idx_next = !store ? idx : widx == LAST ? '0 : widx + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx     <= '0;
            asm_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rec_cnt <= '0;
            err     <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            idx <= idx_next;
            if (store) asm_q <= asm_next;
            if (push) begin
                mem[wr_ptr] <= asm_next;
                wr_ptr      <= wr_ptr == PTR_LAST ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr == PTR_LAST ? '0 : rd_ptr + 1'b1;
                rec_cnt <= rec_cnt + 32'd1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            err   <= err | err_set;
        end
    end

    assign head             = mem[rd_ptr];
    assign bus.word_ready_o = !full;
    assign bus.rec_valid_o  = count != '0;
    assign bus.rec_type_o   = head[XREG_W-1 -: 4];
    assign bus.rec_id_o     = head[XREG_W-5 -: 60];
    assign bus.rec_value_o  = head[XREG_W +: FREG_W];
    assign bus.rec_cnt_o    = rec_cnt;
    assign bus.err_o        = err;
endmodule

// File: tb/tb_cosim_reg_write_deser.sv
// tb_cosim_reg_write_deser: table-driven record checks plus backpressure, gap, reset and protocol sequences.
module tb_cosim_reg_write_deser;
    typedef logic [191:0] rec_t;
    typedef logic [5:0][31:0] item_t;
    typedef struct {
        item_t        w;
        logic [3:0]   typ;
        logic [59:0]  id;
        logic [127:0] val;
        logic [31:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cosim_reg_write_deser_if #(.DPI_W(32), .FREG_W(128)) bus();
    cosim_reg_write_deser #(.XREG_W(64), .FREG_W(128), .DPI_W(32), .OUT_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    vec_t  vecs [3];
    rec_t  got [$];
    item_t exp_q [$];
    int    tests = 0;
    int    fails = 0;

    // records are captured in the half cycle before the edge that pops them
    always @(negedge clk)
        if (!rst && bus.rec_valid_o && bus.rec_ready_i)
            got.push_back({bus.rec_value_o, bus.rec_type_o, bus.rec_id_o});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input rec_t act, input rec_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.word_valid_i = 1'b0;
        bus.word_first_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input logic f, input int gap);
        int n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.word_valid_i = 1'b1;
        bus.word_data_i  = d;
        bus.word_first_i = f;
        @(negedge clk);
        while (!bus.word_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: word_ready_o stuck at 0 for word %0h", d);
        end
        @(posedge clk);
        #1 bus.word_valid_i = 1'b0;
    endtask

    task automatic send_item(input item_t it, input int maxgap);
        for (int i = 0; i < 6; i++)
            send_word(it[i], i == 0, maxgap == 0 ? 0 : int'($urandom_range(maxgap, 0)));
    endtask

    task automatic wait_recs(input int n, input string name);
        int k = 0;
        while (got.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, rec_t'(got.size()), rec_t'(n));
    endtask

    function automatic rec_t got_at(input int i);
        return i < got.size() ? got[i] : '0;
    endfunction

    initial begin
        item_t a, b, c, it;
        bus.word_valid_i = 1'b0;
        bus.word_data_i  = '0;
        bus.word_first_i = 1'b0;
        bus.rec_ready_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_word_ready", rec_t'(bus.word_ready_o), rec_t'(1));
        chk("rst_rec_valid", rec_t'(bus.rec_valid_o), rec_t'(0));
        chk("rst_rec_cnt", rec_t'(bus.rec_cnt_o), rec_t'(0));
        chk("rst_err", rec_t'(bus.err_o), rec_t'(0));
        chk("rst_fields", {bus.rec_value_o, bus.rec_type_o, bus.rec_id_o}, '0);

        vecs[0].w   = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001, 32'h10000000, 32'h00000005};
        vecs[0].typ = 4'h1;
        vecs[0].id  = 60'h5;
        vecs[0].val = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        vecs[0].cnt = 32'd1;
        vecs[1].w   = {32'h4, 32'h3, 32'h2, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[1].typ = 4'hF;
        vecs[1].id  = 60'hFFF_FFFF_FFFF_FFFF;
        vecs[1].val = 128'h00000004_00000003_00000002_00000001;
        vecs[1].cnt = 32'd2;
        vecs[2].w   = {32'h80000000, 32'h0, 32'h0, 32'h0, 32'h3ABCDEF0, 32'h12345678};
        vecs[2].typ = 4'h3;
        vecs[2].id  = 60'hABC_DEF0_1234_5678;
        vecs[2].val = 128'h80000000_00000000_00000000_00000000;
        vecs[2].cnt = 32'd3;

        bus.rec_ready_i = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 6; i++) send_word(vecs[v].w[i], i == 0, 0);
            chk($sformatf("v%0d_valid_latency", v), rec_t'(bus.rec_valid_o), rec_t'(1));
            chk($sformatf("v%0d_type", v), rec_t'(bus.rec_type_o), rec_t'(vecs[v].typ));
            chk($sformatf("v%0d_id", v), rec_t'(bus.rec_id_o), rec_t'(vecs[v].id));
            chk($sformatf("v%0d_value", v), rec_t'(bus.rec_value_o), rec_t'(vecs[v].val));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_one_cycle", v), rec_t'(bus.rec_valid_o), rec_t'(0));
            chk($sformatf("v%0d_cnt", v), rec_t'(bus.rec_cnt_o), rec_t'(vecs[v].cnt));
            got.delete();
        end

        // backpressure: two records fill the FIFO, the third item stalls until release
        do_reset();
        bus.rec_ready_i = 1'b0;
        a = {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'h2000_00A1, 32'hA0};
        b = {32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'h2000_00B1, 32'hB0};
        c = {32'hC5, 32'hC4, 32'hC3, 32'hC2, 32'h2000_00C1, 32'hC0};
        send_item(a, 0);
        chk("bp_ready_one_rec", rec_t'(bus.word_ready_o), rec_t'(1));
        send_item(b, 0);
        chk("bp_ready_full", rec_t'(bus.word_ready_o), rec_t'(0));
        fork
            send_item(c, 0);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_still_stalled", rec_t'(bus.word_ready_o), rec_t'(0));
                chk("bp_head_is_a", {bus.rec_value_o, bus.rec_type_o, bus.rec_id_o}, rec_t'(a));
                bus.rec_ready_i = 1'b1;
                @(posedge clk);
                #1;
                chk("bp_ready_after_pop", rec_t'(bus.word_ready_o), rec_t'(1));
            end
        join
        wait_recs(3, "bp_drain_count");
        chk("bp_rec1", got_at(0), rec_t'(a));
        chk("bp_rec2", got_at(1), rec_t'(b));
        chk("bp_rec3", got_at(2), rec_t'(c));
        @(posedge clk);
        #1;
        chk("bp_cnt", rec_t'(bus.rec_cnt_o), rec_t'(3));

        // random valid gaps with a consumer that always accepts
        do_reset();
        exp_q.delete();
        bus.rec_ready_i = 1'b1;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 6; i++) it[i] = $urandom;
            exp_q.push_back(it);
            send_item(it, 2);
        end
        wait_recs(10, "gap_count");
        for (int k = 0; k < 10; k++) chk($sformatf("gap_rec%0d", k), got_at(k), rec_t'(exp_q[k]));
        @(posedge clk);
        #1;
        chk("gap_cnt", rec_t'(bus.rec_cnt_o), rec_t'(10));

        // reset in the middle of an item
        do_reset();
        for (int i = 0; i < 3; i++) send_word(32'hDEAD0000 + i, i == 0, 0);
        do_reset();
        it = {32'h55, 32'h44, 32'h33, 32'h22, 32'h4000_0011, 32'h00};
        send_item(it, 0);
        wait_recs(1, "rstmid_first");
        repeat (12) @(negedge clk);
        chk("rstmid_count", rec_t'(got.size()), rec_t'(1));
        chk("rstmid_rec", got_at(0), rec_t'(it));
        chk("rstmid_cnt", rec_t'(bus.rec_cnt_o), rec_t'(1));

`ifdef COSIM_DESER_PROTO_CHECK_EN
        // first flag on word 3 restarts assembly from that word
        do_reset();
        send_word(32'h0BAD0000, 1'b1, 0);
        send_word(32'h0BAD0001, 1'b0, 0);
        send_word(32'h0BAD0002, 1'b0, 0);
        it = {32'hF5, 32'hF4, 32'hF3, 32'hF2, 32'h3000_00F1, 32'hF0};
        send_item(it, 0);
        wait_recs(1, "restart_first");
        repeat (12) @(negedge clk);
        chk("restart_count", rec_t'(got.size()), rec_t'(1));
        chk("restart_rec", got_at(0), rec_t'(it));
        chk("restart_err", rec_t'(bus.err_o), rec_t'(1));
        // stray word without first flag at index 0
        do_reset();
        chk("stray_err_clear", rec_t'(bus.err_o), rec_t'(0));
        send_word(32'h57A4_0000, 1'b0, 0);
        chk("stray_err_set", rec_t'(bus.err_o), rec_t'(1));
        it = {32'hE5, 32'hE4, 32'hE3, 32'hE2, 32'h1000_00E1, 32'hE0};
        send_item(it, 0);
        wait_recs(1, "stray_count");
        chk("stray_rec", got_at(0), rec_t'(it));
        chk("stray_err_sticky", rec_t'(bus.err_o), rec_t'(1));
`else
        // without the check, word_first_i has no effect and indexing is positional
        do_reset();
        it = {32'h95, 32'h94, 32'h93, 32'h92, 32'h2000_0091, 32'h90};
        for (int i = 0; i < 6; i++) send_word(it[i], i == 3, 0);
        wait_recs(1, "nofirst_count");
        chk("nofirst_rec", got_at(0), rec_t'(it));
        chk("nofirst_err", rec_t'(bus.err_o), rec_t'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
